// File: rtl/sum3_arbiter.sv
// Round-robin sharer of one sum-every-3 datapath; grants whole 3-sample groups and tags each sum with its owner.
// Latency: grant 1 cycle after req while idle; tagged result 2 cycles after the third accepted sample.
// Backpressure: only the owner sees o_rdy; others wait for the group to end; valid gaps just stretch the group.
module sum3_arbiter #(
  parameter int N   = 4,
  parameter int IW  = 4,
  parameter int OW  = 6,
  parameter int IDW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic [N-1:0]    i_dval,
  input  logic [N*IW-1:0] i,
  output logic [N-1:0]    o_rdy,
  output logic [N-1:0]    o_gnt,
  output logic            sum_rst_n,
  output logic            sum_dval,
  output logic [IW-1:0]   sum_i,
  input  logic            sum_o_dval,
  input  logic [OW-1:0]   sum_o,
  output logic            o_dval,
  output logic [IDW-1:0]  o_id,
  output logic [OW-1:0]   o,
  output logic            o_err
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t         state, state_nxt;
  logic [IDW-1:0] owner, owner_nxt;
  logic [IDW-1:0] last, last_nxt;
  logic [1:0]     cnt, cnt_nxt;
  logic           pend;
  logic [IDW-1:0] pend_id;

  logic           accept;
  logic           third;
  logic [IW-1:0]  sel_sample;
  logic [IDW-1:0] arb_start;
  logic [IDW-1:0] arb_idx;
  logic [IDW-1:0] arb_id;
  logic           arb_found;

  // The datapath is cleared together with this block so groups restart aligned.
  assign sum_rst_n = !rst;

  // Search starts after `last` when idle, after the finishing owner at group end.
  assign arb_start = (state == BUSY) ? owner : last;

  // Round-robin pick: scan far-to-near so the nearest requester after arb_start wins.
  always_comb begin
    arb_found = 1'b0;
    arb_id    = '0;
    arb_idx   = '0;
    for (int k = N; k >= 1; k--) begin
      arb_idx = IDW'((int'(arb_start) + k) % N);
      if (req[arb_idx]) begin
        arb_found = 1'b1;
        arb_id    = arb_idx;
      end
    end
  end

  // One-hot grant and ready for the current owner; zero while idle.
  always_comb begin
    o_gnt = '0;
    if (state == BUSY) o_gnt[owner] = 1'b1;
  end

  assign o_rdy = o_gnt;

  // Owner's sample mux, feeding the datapath only on an accepted beat.
  always_comb begin
    sel_sample = '0;
    for (int k = 0; k < N; k++) begin
      if (owner == IDW'(k)) sel_sample = i[k*IW +: IW];
    end
  end

  assign accept   = (state == BUSY) && i_dval[owner];
  assign third    = accept && (cnt == 2'd2);
  assign sum_dval = accept;
  assign sum_i    = accept ? sel_sample : '0;

  // Next-state: grab a winner when idle; at the third accept re-arbitrate with no bubble.
  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    last_nxt  = last;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (arb_found) begin
          state_nxt = BUSY;
          owner_nxt = arb_id;
          last_nxt  = arb_id;
          cnt_nxt   = 2'd0;
        end
      end
      BUSY: begin
        if (accept) begin
          if (cnt == 2'd2) begin
            cnt_nxt = 2'd0;
            if (arb_found) begin
              owner_nxt = arb_id;
              last_nxt  = arb_id;
            end else begin
              state_nxt = IDLE;
            end
          end else begin
            cnt_nxt = cnt + 2'd1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Sequencer state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      owner <= '0;
      last  <= IDW'(N - 1);
      cnt   <= 2'd0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      last  <= last_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Result path: the datapath must answer exactly one cycle after a third accept;
  // a missing or unexpected sum_o_dval is flagged. pend refills after it is consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend    <= 1'b0;
      pend_id <= '0;
      o_dval  <= 1'b0;
      o_id    <= '0;
      o       <= '0;
      o_err   <= 1'b0;
    end else begin
      o_dval <= pend && sum_o_dval;
      o_err  <= pend ^ sum_o_dval;
      if (pend && sum_o_dval) begin
        o_id <= pend_id;
        o    <= sum_o;
      end
      pend <= third;
      if (third) pend_id <= owner;
    end
  end

endmodule

// File: tb/tb_sum3_arbiter.sv
// Bench for sum3_arbiter: directed scenarios then random traffic, checked against a group-level model.
// Result expectations are scheduled in a queue by due cycle; a small datapath model answers the DUT.
// The datapath model can hide one result or inject a spurious valid to exercise error reporting.
module tb_sum3_arbiter;

  localparam int N   = 4;
  localparam int IW  = 4;
  localparam int OW  = 6;
  localparam int IDW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [N-1:0]    i_dval;
  logic [N*IW-1:0] i;
  logic [N-1:0]    o_rdy;
  logic [N-1:0]    o_gnt;
  logic            sum_rst_n;
  logic            sum_dval;
  logic [IW-1:0]   sum_i;
  logic            sum_o_dval;
  logic [OW-1:0]   sum_o;
  logic            o_dval;
  logic [IDW-1:0]  o_id;
  logic [OW-1:0]   o;
  logic            o_err;

  always #5 clk = ~clk;

  sum3_arbiter #(.N(N), .IW(IW), .OW(OW), .IDW(IDW)) dut (
    .clk(clk), .rst(rst), .req(req), .i_dval(i_dval), .i(i),
    .o_rdy(o_rdy), .o_gnt(o_gnt), .sum_rst_n(sum_rst_n),
    .sum_dval(sum_dval), .sum_i(sum_i),
    .sum_o_dval(sum_o_dval), .sum_o(sum_o),
    .o_dval(o_dval), .o_id(o_id), .o(o), .o_err(o_err)
  );

  // Datapath model: sums every 3 valid samples, result one cycle later.
  logic          dp_suppress;
  logic          dp_spur;
  logic [1:0]    dp_cnt;
  logic [OW-1:0] dp_acc;
  logic [OW-1:0] dp_sum;
  logic          dp_vld;

  always @(posedge clk) begin
    if (!sum_rst_n) begin
      dp_cnt <= 2'd0;
      dp_acc <= '0;
      dp_sum <= '0;
      dp_vld <= 1'b0;
    end else begin
      dp_vld <= 1'b0;
      if (sum_dval) begin
        if (dp_cnt == 2'd2) begin
          dp_sum <= dp_acc + OW'(sum_i);
          dp_vld <= !dp_suppress;
          dp_cnt <= 2'd0;
          dp_acc <= '0;
        end else begin
          dp_acc <= dp_acc + OW'(sum_i);
          dp_cnt <= dp_cnt + 2'd1;
        end
      end
    end
  end

  assign sum_o_dval = dp_vld | dp_spur;
  assign sum_o      = dp_sum;

  // Reference model state: owner (-1 idle), samples taken, running sum, rr pointer.
  typedef struct {
    int due;
    int id;
    int sum;
    bit err;
  } res_t;

  res_t q[$];
  int   m_owner, m_cnt, m_sum, m_last, cyc;
  int   n_assert = 0;
  int   n_fail   = 0;

  function automatic int pick(input logic [N-1:0] r, input int start);
    for (int k = 1; k <= N; k++) begin
      if (r[(start + k) % N]) return (start + k) % N;
    end
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  task automatic check_cycle();
    logic [N-1:0]  eg;
    logic          acc;
    logic [IW-1:0] es;
    res_t          e;
    eg  = '0;
    acc = 1'b0;
    es  = '0;
    if (m_owner >= 0) begin
      eg[m_owner] = 1'b1;
      acc = i_dval[m_owner];
      if (acc) es = i[m_owner*IW +: IW];
    end
    chk("o_gnt", o_gnt, eg);
    chk("o_rdy", o_rdy, eg);
    chk("sum_dval", sum_dval, acc);
    chk("sum_i", sum_i, es);
    chk("sum_rst_n", sum_rst_n, !rst);
    if (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      if (e.err) begin
        chk("o_err_expected", o_err, 1);
        chk("o_dval_on_err", o_dval, 0);
      end else begin
        chk("o_dval", o_dval, 1);
        chk("o_id", o_id, e.id);
        chk("o_sum", o, e.sum);
        chk("o_err_clean", o_err, 0);
      end
    end else begin
      chk("o_dval_idle", o_dval, 0);
      chk("o_err_idle", o_err, 0);
    end
  endtask

  task automatic model_advance();
    int w;
    if (rst) begin
      m_owner = -1;
      m_cnt   = 0;
      m_sum   = 0;
      m_last  = N - 1;
      q.delete();
    end else begin
      if (m_owner < 0) begin
        w = pick(req, m_last);
        if (w >= 0) begin
          m_owner = w;
          m_last  = w;
          m_cnt   = 0;
          m_sum   = 0;
        end
      end else if (i_dval[m_owner]) begin
        m_sum += int'(i[m_owner*IW +: IW]);
        m_cnt++;
        if (m_cnt == 3) begin
          q.push_back('{cyc + 2, m_owner, m_sum, dp_suppress});
          w = pick(req, m_owner);
          if (w >= 0) begin
            m_owner = w;
            m_last  = w;
          end else begin
            m_owner = -1;
          end
          m_cnt = 0;
          m_sum = 0;
        end
      end
      if (dp_spur) q.push_back('{cyc + 1, 0, 0, 1'b1});
    end
    cyc++;
  endtask

  // One clock: inputs already driven at the falling edge; check, predict, advance.
  task automatic cycle();
    #1;
    check_cycle();
    model_advance();
    @(negedge clk);
  endtask

  task automatic set_sample(input int k, input logic [IW-1:0] v);
    i[k*IW +: IW] = v;
  endtask

  initial begin
    rst = 1'b1; req = '0; i_dval = '0; i = '0;
    dp_suppress = 1'b0; dp_spur = 1'b0;
    m_owner = -1; m_cnt = 0; m_sum = 0; m_last = N - 1; cyc = 0;
    repeat (2) @(negedge clk);

    // Reset held with every requester asking.
    req = 4'b1111;
    repeat (3) cycle();
    chk("reset_o_id", o_id, 0);
    chk("reset_o", o, 0);
    rst = 1'b0;
    cycle();
    chk("first_grant", o_gnt, 4'b0001);

    // Single group from requester 0: 1+2+3.
    req = '0;
    i_dval = 4'b0001;
    set_sample(0, 4'd1); cycle();
    set_sample(0, 4'd2); cycle();
    set_sample(0, 4'd3); cycle();
    i_dval = '0; i = '0;
    cycle();
    cycle();
    chk("single_sum", o, 6);
    cycle();

    // Full contention with all-15 samples, starting from reset priority.
    rst = 1'b1; cycle(); rst = 1'b0;
    req = 4'b1111; i_dval = 4'b1111; i = 16'hFFFF;
    repeat (13) cycle();
    req = '0;
    repeat (3) cycle();
    i_dval = '0; i = '0;
    repeat (3) cycle();

    // Valid gaps from requester 2 while requester 1 waits.
    req = 4'b0100; cycle();
    req = 4'b0010;
    i_dval = 4'b0100; set_sample(2, 4'd4); cycle();
    i_dval = '0; cycle(); cycle();
    chk("gap_hold", o_gnt, 4'b0100);
    i_dval = 4'b0100; set_sample(2, 4'd5); cycle();
    set_sample(2, 4'd6); cycle();
    req = '0; i = '0;
    chk("gap_next_owner", o_gnt, 4'b0010);
    i_dval = 4'b0010; set_sample(1, 4'd1); repeat (3) cycle();
    i_dval = '0; i = '0;
    repeat (3) cycle();

    // Reset in the middle of requester 3's group, then a clean group.
    req = 4'b1000; cycle();
    req = '0; i_dval = 4'b1000; set_sample(3, 4'd9);
    repeat (2) cycle();
    rst = 1'b1; i_dval = '0; cycle();
    rst = 1'b0; req = 4'b1000; cycle();
    req = '0; i_dval = 4'b1000; set_sample(3, 4'd7);
    repeat (3) cycle();
    i_dval = '0; i = '0;
    cycle(); cycle();
    chk("post_reset_sum", o, 21);
    cycle();

    // Datapath withholds a result.
    dp_suppress = 1'b1;
    req = 4'b0001; cycle();
    req = '0; i_dval = 4'b0001; set_sample(0, 4'd5);
    repeat (3) cycle();
    i_dval = '0; i = '0;
    repeat (3) cycle();
    dp_suppress = 1'b0;

    // Spurious datapath valid while idle.
    dp_spur = 1'b1; cycle();
    dp_spur = 1'b0; repeat (2) cycle();

    // Random traffic with occasional resets.
    repeat (500) begin
      req    = N'($urandom);
      i_dval = N'($urandom);
      i      = (N*IW)'($urandom);
      rst    = ($urandom_range(0, 63) == 0);
      cycle();
    end
    rst = 1'b0; req = '0; i_dval = '0;
    repeat (4) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/sum3_arbiter.md
# sum3_arbiter

Round-robin arbiter and sequencer that shares one sum-every-3 datapath (4-bit samples in, 6-bit sum of each 3 accepted samples out, 1-cycle latency) between N requesters. It grants the datapath for whole 3-sample groups so the datapath's internal group counter never straddles two owners. It drives the datapath's input and reset, and checks the datapath's output timing. It then returns each sum tagged with the owner's ID.

## Interface
- N, 4: number of requesters (2..8)
- IW, 4: sample width; fixed to match the datapath
- OW, 6: sum width; fixed to match the datapath
- IDW, $clog2(N): requester ID width
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- req  in  N  per-requester group request, level
- i_dval  in  N  per-requester sample valid
- i  in  N*IW  per-requester sample; requester k uses bits [k*IW +: IW]
- o_rdy  out  N  sample accept; a sample is accepted when i_dval[k] & o_rdy[k]
- o_gnt  out  N  one-hot current owner; all zero when idle
- sum_rst_n  out  1  datapath reset (active-low), equal to !rst, combinational
- sum_dval  out  1  datapath sample valid
- sum_i  out  IW  datapath sample
- sum_o_dval  in  1  datapath result valid
- sum_o  in  OW  datapath result
- o_dval  out  1  tagged result valid, 1-cycle pulse
- o_id  out  IDW  owner ID of the result
- o  out  OW  result sum
- o_err  out  1  1-cycle pulse on a datapath timing mismatch

## Operation
- States: IDLE and BUSY. BUSY carries an owner ID and a 2-bit accept count cnt in 0..2.
- Round-robin pointer `last`: on reset, last = N-1, so requester 0 has first priority. Search order is last+1, last+2, … mod N.
- IDLE: if any req bit is set, take the winner, go to BUSY with cnt=0, and set last=winner. Otherwise stay in IDLE.
- BUSY: o_rdy = o_gnt, one-hot on the owner. All other o_rdy bits are 0.
  - On each accepted sample, sum_dval=1 and sum_i = the owner's sample, both combinational in the same cycle. Otherwise sum_dval=0 and sum_i=0.
  - cnt increments on each accept.
- Third accept (cnt==2 and accept):
  - Latch the owner ID into the pending register and set pend=1.
  - Arbitrate in the same cycle over all req bits, the current owner included, starting from the owner+1 position.
  - If a winner exists, stay in BUSY with the new owner and cnt=0. Otherwise go to IDLE.
- req is sampled only at arbitration points. Deasserting req mid-group does not end the group; the owner keeps the grant until 3 samples are accepted.
- Valid gaps from the owner are legal and only extend the group. Other requesters wait for the group to finish.
- Result path, in the cycle after pend is set:
  - Expect sum_o_dval=1.
  - If it is present: register o_dval=1, o_id = the pending ID, o = sum_o.
  - If it is absent: register o_err=1 and o_dval=0.
  - pend clears in either case.
- Any sum_o_dval=1 while pend=0 registers o_err=1 and does not produce o_dval.
- Width: the sum is at most 3*15 = 45 and fits in OW=6. The block passes sum_o through unmodified.

## Timing
- Reset state:
  - state=IDLE, cnt=0, last=N-1, pend=0.
  - o_gnt=0, o_rdy=0, sum_dval=0, sum_i=0.
  - o_dval=0, o_id=0, o=0, o_err=0.
  - sum_rst_n=0 while rst=1.
- Grant latency: req rises at cycle c while IDLE → o_gnt/o_rdy are asserted from cycle c+1.
- Back-to-back groups: the third accept is at t; the next owner's o_rdy is asserted at t+1 with no idle bubble. Minimum group length is 3 cycles.
- Result latency: the third accept is at t; the datapath result arrives at t+1; o_dval/o_id/o are valid at t+2. One pending slot is sufficient because groups are at least 3 cycles long.
- Simultaneous events:
  - A new third-accept in the same cycle as the pend check: the pending register is refilled after the old value is consumed; no loss.
  - The owner's own req is still high at group end: other requesters with req set win first; the owner wins only if it is alone.
- Reset mid-group: rst=1 forces reset state next edge. The partial group is dropped and no o_dval or o_err is produced. sum_rst_n also clears the datapath, so the first group after reset starts aligned.

## Test plan
- Reset: hold rst 3 cycles with req=4'b1111 → o_gnt=0, o_rdy=0, o_dval=0, o_err=0, sum_rst_n=0. Release → o_gnt=4'b0001 next cycle.
- Single group: requester 0 sends samples 1, 2, 3 on consecutive cycles from t-2 to t → sum_dval high for 3 cycles. At t+2: o_dval=1, o_id=0, o=6.
- Full contention: req=4'b1111, each requester streams three samples of value 15 → grants in order 0, 1, 2, 3 with no gaps. Results every 3 cycles with o=45 and o_id=0, 1, 2, 3. Then grant returns to 0.
- Valid gaps: requester 2 is owner and sends 4, then 2 idle cycles, then 5, 6, while req[1] is high → o_gnt stays 4'b0100 until the third accept. o=15, o_id=2. Then requester 1 is granted.
- Reset mid-group: rst is pulsed after requester 3's second sample → no o_dval. Afterwards requester 3 sends 7, 7, 7 → o=21, not a sum polluted by pre-reset samples.
- Error check: the datapath model suppresses sum_o_dval after one group → o_err=1 at t+2 and o_dval=0. A spurious sum_o_dval while idle → o_err pulse one cycle later.
